// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// State encoding, stall patterns, the timeout redirect vector and the memory-wait limit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  // Stall bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb (wb is never stalled)
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
  localparam logic [31:0] MEM_TIMEOUT_VEC = 32'h0000_0020;

  localparam int MEM_TIMEOUT_LIMIT = 16;
  localparam int WAIT_CNT_W        = $clog2(MEM_TIMEOUT_LIMIT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wait_timer.sv
// Memory-wait timeout counter: counts consecutive un-acked cycles,
// flags expiry on the last allowed cycle of the wait.
module wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int LIMIT = MEM_TIMEOUT_LIMIT,
  parameter int W     = WAIT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // The clearing cycle is itself the first un-acked cycle, so clear+enable restarts at 1
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = enable ? ONE : '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: generates per-stage stalls for load-use, divide
// and memory waits, and a one-cycle flush with redirect PC on exceptions or memory timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        div_start,
  input  logic        div_ready,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        excp_valid,
  input  logic [31:0] excp_vector,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt
);

  state_e      state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [5:0]  stall_raw;
  logic        timer_clear, timer_en, timer_expired;

  wait_timer #(
    .LIMIT (MEM_TIMEOUT_LIMIT),
    .W     (WAIT_CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    new_pc_d      = new_pc_q;
    mem_timeout_d = 1'b0;
    stall_raw     = STALL_NONE;
    timer_clear   = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      ST_RUN: begin
        // A completed divide or acked access is not a request, so lower priorities still apply
        if (excp_valid) begin
          new_pc_d = excp_vector;
          state_d  = ST_FLUSH;
        end else if (mem_req && !mem_ack) begin
          stall_raw   = STALL_MEM;
          timer_clear = 1'b1;
          timer_en    = 1'b1;
          state_d     = ST_MEM_WAIT;
        end else if (div_start && !div_ready) begin
          stall_raw = STALL_EX;
          state_d   = ST_DIV_WAIT;
        end else if (stallreq_id) begin
          stall_raw = STALL_ID;
        end
      end

      ST_DIV_WAIT: begin
        if (excp_valid) begin
          new_pc_d = excp_vector;
          state_d  = ST_FLUSH;
        end else if (div_ready) begin
          state_d = ST_RUN;
        end else begin
          stall_raw = STALL_EX;
        end
      end

      ST_MEM_WAIT: begin
        if (excp_valid) begin
          new_pc_d = excp_vector;
          state_d  = ST_FLUSH;
        end else if (mem_ack) begin
          state_d = ST_RUN;
        end else begin
          stall_raw = STALL_MEM;
          timer_en  = 1'b1;
          if (timer_expired) begin
            new_pc_d      = MEM_TIMEOUT_VEC;
            mem_timeout_d = 1'b1;
            state_d       = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stall       = rst ? STALL_NONE : stall_raw;
    stall_cnt_d = stall[0] ? sat_inc16(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      new_pc_q      <= ZERO_WORD;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      new_pc_q      <= new_pc_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign flush       = (state_q == ST_FLUSH) && !rst;
  assign new_pc      = new_pc_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: each step drives one cycle of inputs,
// queues the outputs expected in that cycle, and compares them at the falling edge.
module tb_pipe_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mem_timeout;
    logic [15:0] stall_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, div_start, div_ready, mem_req, mem_ack, excp_valid;
  logic [31:0] excp_vector;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mem_timeout;
  logic [15:0] stall_cnt;

  exp_t expQ[$];
  int   checkCnt = 0;
  int   passCnt  = 0;

  pipe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .div_start   (div_start),
    .div_ready   (div_ready),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .excp_valid  (excp_valid),
    .excp_vector (excp_vector),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [5:0] s, input logic f, input logic [31:0] pc,
                              input logic to, input logic [15:0] cnt);
    exp_t e;
    e.stall       = s;
    e.flush       = f;
    e.new_pc      = pc;
    e.mem_timeout = to;
    e.stall_cnt   = cnt;
    return e;
  endfunction

  task automatic applyStimulus(input logic r, input logic id, input logic ds, input logic dr,
                               input logic mr, input logic ma, input logic ev,
                               input logic [31:0] vec, input exp_t e);
    rst         = r;
    stallreq_id = id;
    div_start   = ds;
    div_ready   = dr;
    mem_req     = mr;
    mem_ack     = ma;
    excp_valid  = ev;
    excp_vector = vec;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(negedge clk);
    checkCnt++;
    assert (expQ.size() > 0) passCnt++;
    else $error("[TB] FAIL %s queue: observed empty, expected entry", tag);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkCnt++;
      assert (stall === e.stall) passCnt++;
      else $error("[TB] FAIL %s stall: observed %b expected %b", tag, stall, e.stall);
      checkCnt++;
      assert (flush === e.flush) passCnt++;
      else $error("[TB] FAIL %s flush: observed %b expected %b", tag, flush, e.flush);
      checkCnt++;
      assert (new_pc === e.new_pc) passCnt++;
      else $error("[TB] FAIL %s new_pc: observed %h expected %h", tag, new_pc, e.new_pc);
      checkCnt++;
      assert (mem_timeout === e.mem_timeout) passCnt++;
      else $error("[TB] FAIL %s mem_timeout: observed %b expected %b", tag, mem_timeout, e.mem_timeout);
      checkCnt++;
      assert (stall_cnt === e.stall_cnt) passCnt++;
      else $error("[TB] FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, e.stall_cnt);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic id, input logic ds,
                      input logic dr, input logic mr, input logic ma, input logic ev,
                      input logic [31:0] vec, input exp_t e);
    applyStimulus(r, id, ds, dr, mr, ma, ev, vec, e);
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;
  localparam logic [5:0] SM = 6'b011111;

  initial begin
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd0));
    void'(expQ.pop_front());
    repeat (2) @(posedge clk);
    #1;

    // Reset held with a pending memory request: no stall, all registers cleared
    step("reset", 1, 0, 0, 0, 1, 0, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd0));
    step("idle",  0, 0, 0, 0, 0, 0, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd0));

    // Load-use: a single cycle of ID stall
    step("id_req",  0, 1, 0, 0, 0, 0, 0, 32'h0, mk(SI, 0, 32'h0, 0, 16'd0));
    step("id_done", 0, 0, 0, 0, 0, 0, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd1));

    // Divide: ready after 5 stalled cycles
    for (int i = 0; i < 5; i++)
      step("div_wait", 0, 0, 1, 0, 0, 0, 0, 32'h0, mk(SE, 0, 32'h0, 0, 16'(1 + i)));
    step("div_ready", 0, 0, 1, 1, 0, 0, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd6));
    step("div_after", 0, 0, 0, 0, 0, 0, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd6));

    // Memory access acked in the same cycle: no stall
    step("mem_fast", 0, 0, 0, 0, 1, 1, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd6));

    // Memory acked on cycle 3
    for (int i = 0; i < 3; i++)
      step("mem_wait", 0, 0, 0, 0, 1, 0, 0, 32'h0, mk(SM, 0, 32'h0, 0, 16'(6 + i)));
    step("mem_ack",   0, 0, 0, 0, 1, 1, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd9));
    step("mem_after", 0, 0, 0, 0, 0, 0, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd9));

    // MEM outranks DIV and ID
    step("prio_mem",  0, 1, 1, 0, 1, 0, 0, 32'h0, mk(SM, 0, 32'h0, 0, 16'd9));
    step("prio_ack",  0, 0, 0, 0, 1, 1, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd10));
    step("prio_idle", 0, 0, 0, 0, 0, 0, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd10));

    // Memory never acked: 16 stall cycles then timeout flush
    for (int i = 0; i < 16; i++)
      step("to_wait", 0, 0, 0, 0, 1, 0, 0, 32'h0, mk(SM, 0, 32'h0, 0, 16'(10 + i)));
    step("to_flush", 0, 0, 0, 0, 1, 0, 0, 32'h0, mk(S0, 1, 32'h0000_0020, 1, 16'd26));
    step("to_after", 0, 0, 0, 0, 0, 0, 0, 32'h0, mk(S0, 0, 32'h0000_0020, 0, 16'd26));

    // Exception collides with MEM and ID requests; inputs ignored during the flush
    step("excp_req",   0, 1, 0, 0, 1, 0, 1, 32'hBFC0_0380, mk(S0, 0, 32'h0000_0020, 0, 16'd26));
    step("excp_flush", 0, 1, 1, 0, 1, 0, 1, 32'hDEAD_BEEF, mk(S0, 1, 32'hBFC0_0380, 0, 16'd26));
    step("excp_hold",  0, 0, 0, 0, 0, 0, 0, 32'h0,         mk(S0, 0, 32'hBFC0_0380, 0, 16'd26));

    // Exception aborts a divide wait
    step("abort_div",   0, 0, 1, 0, 0, 0, 0, 32'h0,         mk(SE, 0, 32'hBFC0_0380, 0, 16'd26));
    step("abort_excp",  0, 0, 1, 0, 0, 0, 1, 32'h8000_0180, mk(S0, 0, 32'hBFC0_0380, 0, 16'd27));
    step("abort_flush", 0, 0, 0, 0, 0, 0, 0, 32'h0,         mk(S0, 1, 32'h8000_0180, 0, 16'd27));

    // Reset during a divide wait
    step("rst_div0", 0, 0, 1, 0, 0, 0, 0, 32'h0, mk(SE, 0, 32'h8000_0180, 0, 16'd27));
    step("rst_div1", 0, 0, 1, 0, 0, 0, 0, 32'h0, mk(SE, 0, 32'h8000_0180, 0, 16'd28));
    step("rst_hit",  1, 0, 1, 0, 0, 0, 0, 32'h0, mk(S0, 0, 32'h8000_0180, 0, 16'd29));
    step("rst_run",  0, 0, 0, 0, 0, 0, 0, 32'h0, mk(S0, 0, 32'h0, 0, 16'd0));

    // Reset during a memory wait with an exception pending: no flush afterwards
    step("rst_mem0",  0, 0, 0, 0, 1, 0, 0, 32'h0,         mk(SM, 0, 32'h0, 0, 16'd0));
    step("rst_mem1",  1, 0, 0, 0, 1, 0, 1, 32'h1234_5678, mk(S0, 0, 32'h0, 0, 16'd1));
    step("rst_mem2",  0, 0, 0, 0, 0, 0, 0, 32'h0,         mk(S0, 0, 32'h0, 0, 16'd0));
    step("rst_mem3",  0, 0, 0, 0, 0, 0, 0, 32'h0,         mk(S0, 0, 32'h0, 0, 16'd0));

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset (`RstEnable`); one clock domain only.
REQ-003 SHALL have ports: stallreq_id  in  1  ID load-use hazard request.
REQ-004 SHALL have ports: div_start  in  1  EX issues multi-cycle divide.
REQ-005 SHALL have ports: div_ready  in  1  divider result valid.
REQ-006 SHALL have ports: mem_req  in  1  MEM-stage data access.
REQ-007 SHALL have ports: mem_ack  in  1  data memory done.
REQ-008 SHALL have ports: excp_valid  in  1  exception or eret from MEM.
REQ-009 SHALL have ports: excp_vector  in  32  redirect PC.
REQ-010 SHALL have ports: stall  out  6  bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
REQ-011 SHALL have ports: flush  out  1  one-cycle pipeline flush.
REQ-012 SHALL have ports: new_pc  out  32  PC target while flush=1.
REQ-013 SHALL have ports: mem_timeout  out  1  one-cycle pulse on memory timeout.
REQ-014 SHALL have ports: stall_cnt  out  16  count of stalled-PC cycles.

Function
REQ-015 SHALL implement a registered FSM: RUN, DIV_WAIT, MEM_WAIT, FLUSH.
REQ-016 SHALL drive stall combinationally from state and inputs, so it takes effect in the request cycle.
REQ-017 SHALL use these stall encodings: ID request 6'b000111; EX request 6'b001111; MEM request 6'b011111; none 6'b000000.
REQ-018 SHALL apply priority excp_valid > MEM > DIV > ID when requests coincide.
REQ-019 RUN: excp_valid -> stall=0, latch excp_vector, next state FLUSH.
REQ-020 RUN: mem_req & !mem_ack -> stall=011111, wait counter cleared, next state MEM_WAIT.
REQ-021 RUN: mem_req & mem_ack -> no stall, stay in RUN.
REQ-022 RUN: div_start & !div_ready -> stall=001111, next state DIV_WAIT.
REQ-023 RUN: div_start & div_ready -> no stall.
REQ-024 RUN: stallreq_id alone -> stall=000111 for that cycle only, no state change.
REQ-025 MEM_WAIT: stall=011111 while !mem_ack, wait counter incrementing.
REQ-026 MEM_WAIT: mem_ack -> stall=0 that cycle, next state RUN.
REQ-027 MEM_WAIT: on the 16th consecutive un-acked cycle (counter==15), stall=011111 and next state FLUSH with new_pc=`MemTimeoutVec` (32'h0000_0020); mem_timeout pulses one cycle concurrently with that flush.
REQ-028 DIV_WAIT: stall=001111 until div_ready; the div_ready cycle has stall=0, next state RUN.
REQ-029 DIV_WAIT / MEM_WAIT: excp_valid aborts the wait -> FLUSH.
REQ-030 FLUSH: flush=1 and new_pc=latched vector for exactly one cycle, stall=0, then RUN; inputs are ignored in FLUSH.
REQ-031 new_pc SHALL hold its last value when flush=0.
REQ-032 stall_cnt SHALL increment on each cycle with stall[0]=1 and saturate at 16'hFFFF.
REQ-033 stall[5] SHALL be 0 in all states; with mem stalled and wb not stalled, mem_wb inserts a bubble.

Reset
REQ-034 With rst=1 at a clk edge: state=RUN, wait counter=0, new_pc=`ZeroWord`, stall_cnt=0, flush=0, mem_timeout=0.
REQ-035 While rst=1, stall SHALL be 6'b000000.
REQ-036 Reset mid-wait or mid-flush SHALL abandon the operation with no flush pulse afterwards.

Structure
REQ-037 State encodings, stall encodings, `MemTimeoutVec` and the timeout limit (16) SHALL live in defines.v.
REQ-038 The memory-wait timeout counter SHALL be sub-module wait_timer (clear, enable, expired).

Verification
REQ-039 Load-use: stallreq_id=1 for one cycle -> stall=000111 for one cycle, stall_cnt=1.
REQ-040 Divide: div_start held, div_ready after 5 cycles -> stall=001111 for 5 cycles, then 000000; stall_cnt=5.
REQ-041 Memory: mem_req, mem_ack on cycle 3 -> stall=011111 for cycles 0-2, 0 on cycle 3.
REQ-042 Timeout: mem_req, never acked -> 16 stall cycles, then flush=1, new_pc=32'h20, mem_timeout=1 in the same cycle.
REQ-043 Collision: excp_valid with mem_req and stallreq_id, vector 32'hBFC0_0380 -> stall=0, next cycle flush=1, new_pc=32'hBFC0_0380.
REQ-044 Reset during DIV_WAIT -> next cycle RUN, stall=0, stall_cnt=0, no flush.
